m6809_word_mover: RTL and testbench
===================================

# m6809_word_mover

Sequential 16-bit memory transfer unit for the 6809 core. It carries D/X/Y/U/S loads and stores across the core's 8-bit memory bus. Loads are assembled big-endian from two byte reads; stores are split big-endian into two byte writes. It also produces the load/store condition codes (N, Z, V cleared) that the 16-bit ALU passes through unchanged. It sits between the execute sequencer and the bus interface, on the opposite side of the register-file/ALU data path.

## Interface

No parameters; data width fixed at 16, bus width at 8.

- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE or DONE
- dir  in  1  0 = load (read), 1 = store (write); sampled with start
- addr  in  16  effective address of high byte; sampled with start
- wdata  in  16  store word; sampled with start
- busy  out  1  high in RD_HI, RD_LO, WR_HI, WR_LO
- done  out  1  one-cycle completion pulse (state DONE)
- rdata  out  16  assembled load word; held until next accepted load
- n_out  out  1  bit 15 of transferred word, valid from done until next start
- z_out  out  1  transferred word == 16'h0000, same validity
- v_out  out  1  always 0 when done; sequencer writes CC only on done
- mem_addr  out  16  bus address
- mem_rd  out  1  read strobe, held until ready
- mem_wr  out  1  write strobe, held until ready
- mem_wdata  out  8  write byte, valid with mem_wr
- mem_rdata  in  8  read byte, sampled on edge where mem_ready=1 and mem_rd=1
- mem_ready  in  1  bus completion; any number of wait states

## Operation

- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE.
- Start accepted in IDLE or DONE:
  - latch addr into addr_q and wdata into wdata_q;
  - go to RD_HI (dir=0) or WR_HI (dir=1).
- Start is ignored in the other four states; latched operands are not disturbed.
- RD_HI:
  - mem_rd=1, mem_addr=addr_q;
  - on mem_ready, rdata[15:8] <= mem_rdata and go to RD_LO;
  - otherwise stay.
- RD_LO:
  - mem_rd=1, mem_addr=addr_q+1 (16-bit wrap: FFFF -> 0000);
  - on mem_ready, rdata[7:0] <= mem_rdata and go to DONE.
- WR_HI: mem_wr=1, mem_addr=addr_q, mem_wdata=wdata_q[15:8]; on mem_ready go to WR_LO.
- WR_LO: mem_wr=1, mem_addr=addr_q+1 (wrap), mem_wdata=wdata_q[7:0]; on mem_ready go to DONE.
- DONE:
  - done=1, busy=0;
  - with start=0, next state is IDLE; with start=1, back-to-back entry to RD_HI/WR_HI.
- Flags are registered on the transition into DONE:
  - N = word[15], Z = ~|word, V = 0;
  - word = assembled rdata for loads, wdata_q for stores.
- Flags and rdata hold their values through IDLE. For loads, rdata bytes update as each byte is captured (the high byte changes before done).
- mem_rd and mem_wr are never both high. Both are 0 in IDLE and DONE.
- mem_ready outside RD_*/WR_* is ignored.

## Timing

- Reset values:
  - state IDLE;
  - busy, done, mem_rd, mem_wr = 0;
  - mem_addr, mem_wdata = 0;
  - rdata = 16'h0000;
  - n_out, z_out, v_out = 0.
- Reset asserted mid-transfer: strobes drop asynchronously and the transfer is abandoned (no partial rdata guarantee beyond reset value 0). No done is issued.
- Zero-wait latency, with start sampled at edge 0:
  - first strobe high in cycle 1;
  - second byte in cycle 2;
  - done high in cycle 3.
- Each wait state (mem_ready=0 during a strobe cycle) adds one cycle.
- Back-to-back: start in DONE cycle puts the next transfer's first strobe in the following cycle, giving 3-cycle throughput.
- Strobes and address are registered outputs (no combinational path from mem_ready to strobes).

## Test plan

- Load, zero wait: addr=2000, mem[2000]=12, mem[2001]=34, start, dir=0 -> strobes at 2000 then 2001 in cycles 1–2; done in cycle 3; rdata=1234, N=0, Z=0, V=0.
- Store, 2 wait states on the high byte: addr=4000, wdata=8000 -> mem_wr at 4000 with data 80 held 3 cycles, then 4001 with data 00; done in cycle 5; N=1, Z=0, V=0.
- Wrap: load at addr=FFFF, mem[FFFF]=AB, mem[0000]=CD -> second read at 0000; rdata=ABCD, N=1.
- Zero word, load with both bytes 00 -> Z=1, N=0. Then start during RD_LO of a following load -> ignored, no extra bus cycles.
- Back-to-back: store 5555 at 1000, start held in DONE with load at 1000 -> read strobe in the cycle after done; rdata=5555.
- Reset: rst_n low during WR_LO -> mem_wr low immediately; all outputs at reset values. After release, IDLE and done stays 0.

Source files
------------

// File: rtl/m6809_word_mover_if.sv
// Bundles the sequencer request/response and 8-bit memory bus of the word mover.
// slave = the mover itself, master = the sequencer and bus environment driving it.
interface m6809_word_mover_if;
  logic        start;
  logic        dir;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        n_out;
  logic        z_out;
  logic        v_out;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport slave (
    input  start, dir, addr, wdata, mem_rdata, mem_ready,
    output busy, done, rdata, n_out, z_out, v_out,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output start, dir, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, rdata, n_out, z_out, v_out,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/m6809_word_mover.sv
// 16-bit load/store over an 8-bit bus, big-endian, with load/store N/Z/V flags.
// Zero-wait transfer takes 3 cycles start-to-done; each mem_ready=0 cycle adds one.
module m6809_word_mover (
  input  logic                 clk,
  input  logic                 rst_n,
  m6809_word_mover_if.slave    bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_HI = 3'd1;
  localparam logic [2:0] RD_LO = 3'd2;
  localparam logic [2:0] WR_HI = 3'd3;
  localparam logic [2:0] WR_LO = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        n_q, n_d;
  logic        z_q, z_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    n_d     = n_q;
    z_d     = z_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = bus.dir ? WR_HI : RD_HI;
        end else begin
          state_d = IDLE;
        end
      end
      RD_HI: begin
        if (bus.mem_ready) begin
          rdata_d[15:8] = bus.mem_rdata;
          state_d       = RD_LO;
        end
      end
      RD_LO: begin
        if (bus.mem_ready) begin
          rdata_d[7:0] = bus.mem_rdata;
          // Flags come from the word as it will be, not the half-updated register.
          n_d          = rdata_q[15];
          z_d          = ~|{rdata_q[15:8], bus.mem_rdata};
          state_d      = DONE;
        end
      end
      WR_HI: begin
        if (bus.mem_ready) state_d = WR_LO;
      end
      WR_LO: begin
        if (bus.mem_ready) begin
          n_d     = wdata_q[15];
          z_d     = ~|wdata_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they leave a flop directly.
  always_comb begin
    mem_rd_d    = (state_d == RD_HI) || (state_d == RD_LO);
    mem_wr_d    = (state_d == WR_HI) || (state_d == WR_LO);
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 8'h00;
    if ((state_d == RD_HI) || (state_d == WR_HI)) mem_addr_d = addr_d;
    if ((state_d == RD_LO) || (state_d == WR_LO)) mem_addr_d = addr_d + 16'd1;
    if (state_d == WR_HI) mem_wdata_d = wdata_d[15:8];
    if (state_d == WR_LO) mem_wdata_d = wdata_d[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      n_q         <= n_d;
      z_q         <= z_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = (state_q == RD_HI) || (state_q == RD_LO) ||
                         (state_q == WR_HI) || (state_q == WR_LO);
  assign bus.done      = (state_q == DONE);
  assign bus.rdata     = rdata_q;
  assign bus.n_out     = n_q;
  assign bus.z_out     = z_q;
  assign bus.v_out     = 1'b0;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_m6809_word_mover.sv
// Directed bench for m6809_word_mover: loads, stores, wait states, wrap,
// ignored start, back-to-back and mid-transfer reset.
module tb_m6809_word_mover;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [7:0] mem [0:65535];

  m6809_word_mover_if bif ();

  m6809_word_mover dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bif.mem_rdata = mem[bif.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic d, input logic [15:0] a, input logic [15:0] w);
    bif.start = 1'b1;
    bif.dir   = d;
    bif.addr  = a;
    bif.wdata = w;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bif.start     = 1'b0;
    bif.dir       = 1'b0;
    bif.addr      = 16'h0000;
    bif.wdata     = 16'h0000;
    bif.mem_ready = 1'b1;
    mem[16'h2000] = 8'h12; mem[16'h2001] = 8'h34;
    mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
    mem[16'h3000] = 8'h00; mem[16'h3001] = 8'h00;
    mem[16'h3100] = 8'h5A; mem[16'h3101] = 8'hA5;
    mem[16'h1000] = 8'h55; mem[16'h1001] = 8'h55;

    tick(); tick();
    check("rst_busy",  {15'd0, bif.busy},   16'd0);
    check("rst_done",  {15'd0, bif.done},   16'd0);
    check("rst_rd",    {15'd0, bif.mem_rd}, 16'd0);
    check("rst_wr",    {15'd0, bif.mem_wr}, 16'd0);
    check("rst_addr",  bif.mem_addr,        16'h0000);
    check("rst_rdata", bif.rdata,           16'h0000);
    check("rst_nzv",   {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Load 1234 from 2000, zero wait
    req(1'b0, 16'h2000, 16'h0000);
    tick(); bif.start = 1'b0;
    check("ld_c1_rd",   {15'd0, bif.mem_rd}, 16'd1);
    check("ld_c1_wr",   {15'd0, bif.mem_wr}, 16'd0);
    check("ld_c1_addr", bif.mem_addr,        16'h2000);
    check("ld_c1_busy", {15'd0, bif.busy},   16'd1);
    tick();
    check("ld_c2_rd",   {15'd0, bif.mem_rd}, 16'd1);
    check("ld_c2_addr", bif.mem_addr,        16'h2001);
    check("ld_c2_hi",   {8'd0, bif.rdata[15:8]}, 16'h0012);
    tick();
    check("ld_c3_done", {15'd0, bif.done},   16'd1);
    check("ld_c3_busy", {15'd0, bif.busy},   16'd0);
    check("ld_c3_rd",   {15'd0, bif.mem_rd}, 16'd0);
    check("ld_rdata",   bif.rdata,           16'h1234);
    check("ld_nzv",     {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b000);
    tick();
    check("ld_idle_done", {15'd0, bif.done}, 16'd0);
    check("ld_idle_hold", bif.rdata,         16'h1234);

    // Store 8000 to 4000, two wait states on the high byte
    req(1'b1, 16'h4000, 16'h8000);
    bif.mem_ready = 1'b0;
    tick(); bif.start = 1'b0;
    check("st_c1_wr",   {15'd0, bif.mem_wr}, 16'd1);
    check("st_c1_rd",   {15'd0, bif.mem_rd}, 16'd0);
    check("st_c1_addr", bif.mem_addr,        16'h4000);
    check("st_c1_dat",  {8'd0, bif.mem_wdata}, 16'h0080);
    tick();
    check("st_c2_wr",   {15'd0, bif.mem_wr}, 16'd1);
    check("st_c2_addr", bif.mem_addr,        16'h4000);
    tick();
    check("st_c3_addr", bif.mem_addr,        16'h4000);
    check("st_c3_dat",  {8'd0, bif.mem_wdata}, 16'h0080);
    bif.mem_ready = 1'b1;
    tick();
    check("st_c4_wr",   {15'd0, bif.mem_wr}, 16'd1);
    check("st_c4_addr", bif.mem_addr,        16'h4001);
    check("st_c4_dat",  {8'd0, bif.mem_wdata}, 16'h0000);
    tick();
    check("st_c5_done", {15'd0, bif.done},   16'd1);
    check("st_c5_wr",   {15'd0, bif.mem_wr}, 16'd0);
    check("st_nzv",     {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b100);
    check("st_rdata_hold", bif.rdata,        16'h1234);
    tick();

    // Wrap: load at FFFF reads 0000 second
    req(1'b0, 16'hFFFF, 16'h0000);
    tick(); bif.start = 1'b0;
    check("wr_c1_addr", bif.mem_addr, 16'hFFFF);
    tick();
    check("wr_c2_addr", bif.mem_addr, 16'h0000);
    check("wr_c2_rd",   {15'd0, bif.mem_rd}, 16'd1);
    tick();
    check("wr_rdata",   bif.rdata, 16'hABCD);
    check("wr_nzv",     {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b100);
    tick();

    // Zero word load
    req(1'b0, 16'h3000, 16'h0000);
    tick(); bif.start = 1'b0;
    tick(); tick();
    check("z_done",  {15'd0, bif.done}, 16'd1);
    check("z_rdata", bif.rdata, 16'h0000);
    check("z_nzv",   {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b010);
    tick();

    // Start pulsed during RD_LO must be ignored
    req(1'b0, 16'h3100, 16'h0000);
    tick(); bif.start = 1'b0;
    tick();
    check("ig_c2_addr", bif.mem_addr, 16'h3101);
    req(1'b1, 16'h3200, 16'hFFFF);
    tick(); bif.start = 1'b0;
    check("ig_c3_done", {15'd0, bif.done},   16'd1);
    check("ig_c3_wr",   {15'd0, bif.mem_wr}, 16'd0);
    check("ig_rdata",   bif.rdata, 16'h5AA5);
    check("ig_nzv",     {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b000);
    tick();
    check("ig_c4_rd",   {15'd0, bif.mem_rd}, 16'd0);
    check("ig_c4_wr",   {15'd0, bif.mem_wr}, 16'd0);
    check("ig_c4_busy", {15'd0, bif.busy},   16'd0);

    // Back-to-back: store 5555 then load started in the DONE cycle
    req(1'b1, 16'h1000, 16'h5555);
    tick(); bif.start = 1'b0;
    check("bb_st_dat1", {8'd0, bif.mem_wdata}, 16'h0055);
    tick();
    check("bb_st_addr2", bif.mem_addr, 16'h1001);
    check("bb_st_dat2", {8'd0, bif.mem_wdata}, 16'h0055);
    tick();
    check("bb_st_done", {15'd0, bif.done}, 16'd1);
    check("bb_st_nzv",  {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b000);
    req(1'b0, 16'h1000, 16'h0000);
    tick(); bif.start = 1'b0;
    check("bb_ld_rd",   {15'd0, bif.mem_rd}, 16'd1);
    check("bb_ld_addr", bif.mem_addr, 16'h1000);
    check("bb_ld_done", {15'd0, bif.done}, 16'd0);
    tick(); tick();
    check("bb_ld_done2", {15'd0, bif.done}, 16'd1);
    check("bb_rdata",    bif.rdata, 16'h5555);
    tick();

    // Reset during WR_LO
    req(1'b1, 16'h2222, 16'h1234);
    tick(); bif.start = 1'b0;
    tick();
    check("rs_wrlo_wr", {15'd0, bif.mem_wr}, 16'd1);
    check("rs_wrlo_addr", bif.mem_addr, 16'h2223);
    #1 rst_n = 1'b0;
    #1;
    check("rs_wr",    {15'd0, bif.mem_wr},  16'd0);
    check("rs_rd",    {15'd0, bif.mem_rd},  16'd0);
    check("rs_addr",  bif.mem_addr,         16'h0000);
    check("rs_dat",   {8'd0, bif.mem_wdata}, 16'h0000);
    check("rs_busy",  {15'd0, bif.busy},    16'd0);
    check("rs_rdata", bif.rdata,            16'h0000);
    check("rs_nzv",   {13'd0, bif.n_out, bif.z_out, bif.v_out}, 16'b000);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rs_post_done1", {15'd0, bif.done}, 16'd0);
    check("rs_post_busy",  {15'd0, bif.busy}, 16'd0);
    tick();
    check("rs_post_done2", {15'd0, bif.done}, 16'd0);
    check("rs_post_wr",    {15'd0, bif.mem_wr}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
